regfile_mp: RTL and testbench

//  Parametrised multi-port register file; successor to the fixed 3-read/1-write regfile.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_wr_merge.sv | 26 ++
 rtl/regfile_mp.sv | 123 ++++++++++++
 tb/tb_regfile_mp.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Also provides a packed-slice accessor for flattened multi-port buses.
package regfile_pkg;

    localparam int DEF_ADDR_BITS = 6;
    localparam int DEF_REG_WIDTH = 32;
    localparam int DEF_RD_PORTS  = 3;
    localparam int DEF_WR_PORTS  = 2;
    localparam int ZERO_ADDR     = 0;

    // Widest flattened bus and widest single field the slice helper handles.
    localparam int SLICE_VEC_W = 1024;
    localparam int SLICE_W     = 64;

    // Extract field idx of the given width from a flattened bus (port 0 in LSBs).
    function automatic logic [SLICE_W-1:0] slice(input logic [SLICE_VEC_W-1:0] vec,
                                                 input int idx, input int width);
        logic [SLICE_VEC_W-1:0] sh;
        logic [SLICE_W-1:0]     mask;
        sh   = vec >> (idx * width);
        mask = (width >= SLICE_W) ? '1 : ((SLICE_W'(1) << width) - SLICE_W'(1));
        return sh[SLICE_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Port bundle between the issue stage (master) and the register file (slave).
// Signal names match the original flattened regfile port list.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int NUM_ADDR_BITS = DEF_ADDR_BITS,
    parameter int REG_WIDTH     = DEF_REG_WIDTH,
    parameter int NUM_RD_PORTS  = DEF_RD_PORTS,
    parameter int NUM_WR_PORTS  = DEF_WR_PORTS
);
    logic [NUM_WR_PORTS-1:0]               writeEnable;
    logic [NUM_WR_PORTS*NUM_ADDR_BITS-1:0] wrAddr;
    logic [NUM_WR_PORTS*REG_WIDTH-1:0]     wrData;
    logic [NUM_RD_PORTS*NUM_ADDR_BITS-1:0] rdAddr;
    logic [NUM_RD_PORTS*REG_WIDTH-1:0]     rdData;
    logic [NUM_RD_PORTS-1:0]               rdBusy;
    logic                                  rsvEn;
    logic [NUM_ADDR_BITS-1:0]              rsvAddr;
    logic                                  rsvAck;

    modport master (
        output writeEnable, wrAddr, wrData, rdAddr, rsvEn, rsvAddr,
        input  rdData, rdBusy, rsvAck
    );

    modport slave (
        input  writeEnable, wrAddr, wrData, rdAddr, rsvEn, rsvAddr,
        output rdData, rdBusy, rsvAck
    );
endinterface

// File: rtl/regfile_wr_merge.sv
// Priority select across write ports for one address: the highest-index
// enabled port that targets addr supplies the data.
module regfile_wr_merge #(
    parameter int NUM_ADDR_BITS = 6,
    parameter int REG_WIDTH     = 32,
    parameter int NUM_WR_PORTS  = 2
)(
    input  logic [NUM_ADDR_BITS-1:0]                    addr,
    input  logic [NUM_WR_PORTS-1:0]                     wen,
    input  logic [NUM_WR_PORTS-1:0][NUM_ADDR_BITS-1:0]  waddr,
    input  logic [NUM_WR_PORTS-1:0][REG_WIDTH-1:0]      wdata,
    output logic                                        hit,
    output logic [REG_WIDTH-1:0]                        data
);
    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Ascending scan so later (higher) ports override earlier ones.
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (wen[p] && (waddr[p] == addr)) begin
                hit  = 1'b1;
                data = wdata[p];
            end
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write bypass, hardwired R0 and a
// per-register busy scoreboard (reserve at decode, release on writeback).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int NUM_ADDR_BITS = DEF_ADDR_BITS,
    parameter int REG_WIDTH     = DEF_REG_WIDTH,
    parameter int NUM_RD_PORTS  = DEF_RD_PORTS,
    parameter int NUM_WR_PORTS  = DEF_WR_PORTS,
    parameter int BYPASS        = 1,
    parameter int ZERO_REG      = 1
)(
    input  logic          clk,
    input  logic          reset,
    regfile_mp_if.slave   bus
);
    localparam int DEPTH = 1 << NUM_ADDR_BITS;

    logic [NUM_WR_PORTS-1:0][NUM_ADDR_BITS-1:0] wr_addr;
    logic [NUM_WR_PORTS-1:0][REG_WIDTH-1:0]     wr_data;
    logic [DEPTH-1:0][REG_WIDTH-1:0]            mem;
    logic [DEPTH-1:0][REG_WIDTH-1:0]            wr_val;
    logic [DEPTH-1:0]                           busy;
    logic [DEPTH-1:0]                           wr_hit;
    logic [DEPTH-1:0]                           wr_ok;
    logic [DEPTH-1:0]                           rsv_hit;
    logic [NUM_RD_PORTS-1:0][REG_WIDTH-1:0]     rd_data;
    logic [NUM_RD_PORTS-1:0]                    rd_busy;
    logic                                       rsv_valid;
    logic                                       rsv_ok;
    logic                                       rsv_ack;

    function automatic logic is_zero(input logic [NUM_ADDR_BITS-1:0] ad);
        return (ZERO_REG != 0) && (ad == NUM_ADDR_BITS'(ZERO_ADDR));
    endfunction

    assign wr_addr = bus.wrAddr;
    assign wr_data = bus.wrData;

    assign rsv_valid = bus.rsvEn && !is_zero(bus.rsvAddr);
    assign rsv_ok    = rsv_valid && !busy[bus.rsvAddr];

    for (genvar a = 0; a < DEPTH; a++) begin : g_addr
        regfile_wr_merge #(
            .NUM_ADDR_BITS (NUM_ADDR_BITS),
            .REG_WIDTH     (REG_WIDTH),
            .NUM_WR_PORTS  (NUM_WR_PORTS)
        ) u_store (
            .addr  (NUM_ADDR_BITS'(a)),
            .wen   (bus.writeEnable),
            .waddr (wr_addr),
            .wdata (wr_data),
            .hit   (wr_hit[a]),
            .data  (wr_val[a])
        );
        assign wr_ok[a]   = wr_hit[a] && !is_zero(NUM_ADDR_BITS'(a));
        assign rsv_hit[a] = rsv_valid && (bus.rsvAddr == NUM_ADDR_BITS'(a));
    end

    // A reserve always leaves the register busy: either it is newly claimed,
    // or it was already claimed and the refused request leaves it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem     <= '0;
            busy    <= '0;
            rsv_ack <= 1'b0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (wr_ok[a])
                    mem[a] <= wr_val[a];
                if (rsv_hit[a])
                    busy[a] <= 1'b1;
                else if (wr_ok[a])
                    busy[a] <= 1'b0;
            end
            rsv_ack <= rsv_ok;
        end
    end

    for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
        logic [NUM_ADDR_BITS-1:0] ra;
        logic                     byp_hit;
        logic [REG_WIDTH-1:0]     byp_data;
        logic [REG_WIDTH-1:0]     data_q;
        logic                     busy_q;

        assign ra = NUM_ADDR_BITS'(slice(SLICE_VEC_W'(bus.rdAddr), i, NUM_ADDR_BITS));

        regfile_wr_merge #(
            .NUM_ADDR_BITS (NUM_ADDR_BITS),
            .REG_WIDTH     (REG_WIDTH),
            .NUM_WR_PORTS  (NUM_WR_PORTS)
        ) u_byp (
            .addr  (ra),
            .wen   (bus.writeEnable),
            .waddr (wr_addr),
            .wdata (wr_data),
            .hit   (byp_hit),
            .data  (byp_data)
        );

        // Reset gates the bypass path too, so outputs read zero throughout reset.
        always_comb begin
            data_q = mem[ra];
            busy_q = busy[ra];
            if (reset || is_zero(ra)) begin
                data_q = '0;
                busy_q = 1'b0;
            end else if ((BYPASS != 0) && byp_hit) begin
                data_q = byp_data;
                busy_q = rsv_hit[ra];
            end
        end

        assign rd_data[i] = data_q;
        assign rd_busy[i] = busy_q;
    end

    assign bus.rdData = rd_data;
    assign bus.rdBusy = rd_busy;
    assign bus.rsvAck = rsv_ack;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench: a bypass build and a no-bypass build run the
// same stimulus; expectations are queued per cycle and checked on negedge.
module tb_regfile_mp;
    localparam int AB = 6;
    localparam int W  = 32;
    localparam int NR = 3;
    localparam int NW = 2;

    typedef struct {
        int          dut;   // 0 = bypass build, 1 = no-bypass build
        int          kind;  // 0 = rdData, 1 = rdBusy, 2 = rsvAck
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic clk = 1'b0;
    logic reset;
    logic [NW-1:0]         we;
    logic [NW-1:0][AB-1:0] wa;
    logic [NW-1:0][W-1:0]  wd;
    logic [NR-1:0][AB-1:0] ra;
    logic                  rsv_en;
    logic [AB-1:0]         rsv_addr;

    regfile_mp_if #(.NUM_ADDR_BITS(AB), .REG_WIDTH(W), .NUM_RD_PORTS(NR), .NUM_WR_PORTS(NW)) bus_b ();
    regfile_mp_if #(.NUM_ADDR_BITS(AB), .REG_WIDTH(W), .NUM_RD_PORTS(NR), .NUM_WR_PORTS(NW)) bus_n ();

    assign bus_b.writeEnable = we;
    assign bus_b.wrAddr      = wa;
    assign bus_b.wrData      = wd;
    assign bus_b.rdAddr      = ra;
    assign bus_b.rsvEn       = rsv_en;
    assign bus_b.rsvAddr     = rsv_addr;
    assign bus_n.writeEnable = we;
    assign bus_n.wrAddr      = wa;
    assign bus_n.wrData      = wd;
    assign bus_n.rdAddr      = ra;
    assign bus_n.rsvEn       = rsv_en;
    assign bus_n.rsvAddr     = rsv_addr;

    regfile_mp #(.NUM_ADDR_BITS(AB), .REG_WIDTH(W), .NUM_RD_PORTS(NR), .NUM_WR_PORTS(NW),
                 .BYPASS(1), .ZERO_REG(1)) u_dut (.clk(clk), .reset(reset), .bus(bus_b));
    regfile_mp #(.NUM_ADDR_BITS(AB), .REG_WIDTH(W), .NUM_RD_PORTS(NR), .NUM_WR_PORTS(NW),
                 .BYPASS(0), .ZERO_REG(1)) u_dut_nb (.clk(clk), .reset(reset), .bus(bus_n));

    logic [NR-1:0][W-1:0] rdd [2];
    logic [NR-1:0]        rbz [2];
    logic [1:0]           ackv;
    assign rdd[0]  = bus_b.rdData;
    assign rdd[1]  = bus_n.rdData;
    assign rbz[0]  = bus_b.rdBusy;
    assign rbz[1]  = bus_n.rdBusy;
    assign ackv[0] = bus_b.rsvAck;
    assign ackv[1] = bus_n.rsvAck;

    always #5 clk = ~clk;

    function automatic logic [31:0] get(input int d, input int k, input int p);
        case (k)
            0:       return rdd[d][p];
            1:       return {31'b0, rbz[d][p]};
            default: return {31'b0, ackv[d]};
        endcase
    endfunction

    // Monitor: drains every expectation queued for the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e   = q.pop_front();
                act = get(e.dut, e.kind, e.port);
                n_cmp++;
                if (act !== e.val) begin
                    n_err++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h",
                             e.name, e.dut, e.port, act, e.val);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        we     = '0;
        rsv_en = 1'b0;
    endtask

    task automatic wr(input int p, input logic [AB-1:0] a, input logic [W-1:0] d);
        we[p] = 1'b1;
        wa[p] = a;
        wd[p] = d;
    endtask

    task automatic ex(input int d, input int k, input int p, input logic [31:0] v, input string n);
        exp_t e;
        e.dut = d; e.kind = k; e.port = p; e.val = v; e.name = n;
        q.push_back(e);
    endtask

    task automatic ex2(input int k, input int p, input logic [31:0] v, input string n);
        ex(0, k, p, v, n);
        ex(1, k, p, v, n);
    endtask

    initial begin
        reset = 1'b1; we = '0; wa = '0; wd = '0; ra = '0; rsv_en = 1'b0; rsv_addr = '0;

        // Reset: outputs zero even with a write and reserve targeting the read address.
        cyc(); wr(0, 1, 32'hDEAD_BEEF); rsv_en = 1'b1; rsv_addr = 1; ra[0] = 1;
        ex2(0, 0, 0, "rst_data"); ex2(1, 0, 0, "rst_busy"); ex2(2, 0, 0, "rst_ack");
        cyc(); reset = 1'b0;
        ex2(0, 0, 0, "rst_no_store");

        // 1: write R1, read on ports A and C next cycle.
        cyc(); wr(0, 1, 32'h1457_8BB0);
        cyc(); ra[0] = 1; ra[2] = 1;
        ex2(0, 0, 32'h1457_8BB0, "t1_rdA"); ex2(0, 2, 32'h1457_8BB0, "t1_rdC");
        ex2(1, 0, 0, "t1_busy");

        // 2: bypass vs no-bypass on a same-cycle write.
        cyc(); wr(0, 2, 32'hFFFF_FFFF); ra[1] = 2;
        ex(0, 0, 1, 32'hFFFF_FFFF, "t2_bypass"); ex(1, 0, 1, 32'h0, "t2_nobyp_old");
        cyc(); ex2(0, 1, 32'hFFFF_FFFF, "t2_next");

        // 3: write collision on R63, highest port wins.
        cyc(); wr(0, 63, 32'h1); wr(1, 63, 32'hDDDD_DDDD); ra[0] = 63;
        ex(0, 0, 0, 32'hDDDD_DDDD, "t3_byp_win"); ex(1, 0, 0, 32'h0, "t3_nobyp_old");
        cyc(); ex2(0, 0, 32'hDDDD_DDDD, "t3_store_win");

        // 4: R0 is hardwired; write and reserve dropped.
        cyc(); wr(0, 0, 32'h8888_8888); rsv_en = 1'b1; rsv_addr = 0; ra[0] = 0;
        ex2(0, 0, 0, "t4_r0_data_now"); ex2(1, 0, 0, "t4_r0_busy_now");
        cyc(); ex2(0, 0, 0, "t4_r0_data"); ex2(1, 0, 0, "t4_r0_busy"); ex2(2, 0, 0, "t4_r0_ack");

        // 5: scoreboard reserve / refuse / release / reserve-wins.
        cyc(); rsv_en = 1'b1; rsv_addr = 5; ra[0] = 5;
        cyc(); rsv_en = 1'b1; rsv_addr = 5;
        ex2(2, 0, 1, "t5_ack"); ex2(1, 0, 1, "t5_busy");
        cyc(); ex2(2, 0, 0, "t5_ack_refused"); ex2(1, 0, 1, "t5_busy_held");
        cyc(); wr(1, 5, 32'hA5);
        ex(0, 0, 0, 32'hA5, "t5_byp_data"); ex(0, 1, 0, 0, "t5_byp_release");
        ex(1, 1, 0, 1, "t5_nobyp_busy"); ex2(2, 0, 0, "t5_ack_idle");
        cyc(); ex2(0, 0, 32'hA5, "t5_data"); ex2(1, 0, 0, "t5_released");
        cyc(); rsv_en = 1'b1; rsv_addr = 5; wr(0, 5, 32'h5A);
        ex(0, 1, 0, 1, "t5_rsvwr_byp_busy"); ex(0, 0, 0, 32'h5A, "t5_rsvwr_byp_data");
        cyc(); ex2(1, 0, 1, "t5_rsvwr_busy"); ex2(0, 0, 32'h5A, "t5_rsvwr_data");
        ex2(2, 0, 1, "t5_rsvwr_ack");

        // 6: fill R1..R3, then reset in the middle of a write to R4.
        cyc(); wr(0, 1, 32'h11); wr(1, 2, 32'h22);
        cyc(); wr(0, 3, 32'h33); rsv_en = 1'b1; rsv_addr = 3;
        cyc(); ra[0] = 1; ra[1] = 2; ra[2] = 3;
        ex2(0, 0, 32'h11, "t6_r1"); ex2(0, 1, 32'h22, "t6_r2"); ex2(0, 2, 32'h33, "t6_r3");
        ex2(1, 2, 1, "t6_r3_busy");
        cyc(); wr(0, 4, 32'h44); ra[0] = 4; reset = 1'b1;
        for (int p = 0; p < NR; p++) begin
            ex2(0, p, 0, "t6_rst_data");
            ex2(1, p, 0, "t6_rst_busy");
        end
        ex2(2, 0, 0, "t6_rst_ack");
        cyc(); reset = 1'b0; ra[1] = 5;
        ex2(0, 0, 0, "t6_r4_not_written"); ex2(0, 2, 0, "t6_r3_cleared");
        ex2(1, 1, 0, "t6_r5_busy_cleared"); ex2(1, 2, 0, "t6_r3_busy_cleared");

        cyc();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
